// File: rtl/core_fetch_buf.sv
// Instruction fetch buffer: issues sequential L1I fetches, one at a time,
// queues returned instructions with their PC, and drains them to decode.
module core_fetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        l1i_req_val_out,
    output logic [31:0] l1i_req_addr_out,
    input  logic        l1i_ack_in,
    input  logic [31:0] l1i_ack_rdata_in,
    input  logic        redirect_val_in,
    input  logic [31:0] redirect_addr_in,
    output logic        dec_val_out,
    output logic [31:0] dec_inst_out,
    output logic [31:0] dec_pc_out,
    output logic [31:0] dec_pc_4_out,
    input  logic        dec_rdy_in,
    output logic        buf_empty_out,
    output logic        buf_full_out
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc_q   [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic [CW-1:0] count_next;

    always_comb begin
        pop        = (count != '0) && dec_rdy_in;
        push       = (state == WAIT) && l1i_ack_in && !redirect_val_in;
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            // A redirect flushes the queue and wins over any push or pop.
            if (redirect_val_in) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    inst_q[wr_ptr] <= l1i_ack_rdata_in;
                    pc_q[wr_ptr]   <= fetch_pc;
                    wr_ptr         <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count_next;
            end

            case (state)
                IDLE: begin
                    if (redirect_val_in) begin
                        fetch_pc <= redirect_addr_in;
                    end else if (count < FULL) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_val_in) begin
                        fetch_pc <= redirect_addr_in;
                        if (l1i_ack_in) begin
                            state <= IDLE;
                        end else begin
                            // Keep presenting the old address until L1I answers.
                            inflight_pc <= fetch_pc;
                            state       <= DISCARD;
                        end
                    end else if (l1i_ack_in) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        if (count_next == FULL) begin
                            state <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect_val_in) begin
                        fetch_pc <= redirect_addr_in;
                    end
                    if (l1i_ack_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        l1i_req_val_out  = (state == WAIT) || (state == DISCARD);
        l1i_req_addr_out = (state == DISCARD) ? inflight_pc : fetch_pc;
        dec_val_out      = (count != '0);
        dec_inst_out     = inst_q[rd_ptr];
        dec_pc_out       = pc_q[rd_ptr];
        dec_pc_4_out     = pc_q[rd_ptr] + 32'd4;
        buf_empty_out    = (count == '0);
        buf_full_out     = (count == FULL);
    end

endmodule
